pearson_key_packer: RTL and testbench
=====================================

# pearson_key_packer

Upstream feeder for the combinational `pearson` hash stage. It accepts a byte stream over a valid/ready handshake and packs each message, first byte in the most-significant lane, into a zero-padded key of `8*KEY_BYTES` bits. It holds the key stable on its output handshake until the hash consumer accepts it. Messages longer than the key are truncated and flagged.

## Interface
- `KEY_BYTES`, default 5: key length in bytes. The key is `8*KEY_BYTES` = 40 bits and drives `pearson.key` directly.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_byte` in 8: message byte.
- `in_valid` in 1: `in_byte` and `in_last` are valid.
- `in_last` in 1: this byte ends the message.
- `in_ready` out 1: packer accepts a byte this cycle.
- `key` out `8*KEY_BYTES`: packed key. Byte 0 is at `[8*KEY_BYTES-1 -: 8]`, byte i is at `[8*(KEY_BYTES-i)-1 -: 8]`, and unused low bytes are 0.
- `key_len` out 3 (`$clog2(KEY_BYTES+1)`): number of bytes stored, 1..`KEY_BYTES`.
- `key_trunc` out 1: the message exceeded `KEY_BYTES`; bytes beyond it were discarded.
- `key_valid` out 1: `key`, `key_len` and `key_trunc` are valid.
- `key_ready` in 1: consumer takes the key this cycle.

## Operation
- **Handshakes.** An input transfer occurs when `in_valid & in_ready` at a rising edge. An output transfer occurs when `key_valid & key_ready` at a rising edge.
- **State machine**, three states. `in_ready` is a pure decode of the state.
  - FILL: `in_ready`=1, `key_valid`=0.
    - Each accepted byte is written to lane `cnt`, then `cnt` is incremented.
    - Accepted byte with `in_last`=1: go to HOLD.
    - Accepted byte that fills lane `KEY_BYTES-1` with `in_last`=0: go to DROP.
    - If both apply (`in_last`=1 on the final lane), go to HOLD; `key_trunc` stays 0.
  - DROP: `in_ready`=1, `key_valid`=0.
    - Accepted bytes are discarded and `key` is unchanged.
    - The first accepted byte sets `key_trunc`=1.
    - Accepted byte with `in_last`=1: go to HOLD.
  - HOLD: `in_ready`=0, `key_valid`=1.
    - All outputs are stable.
    - On output transfer: `key`←0, `cnt`←0, `key_trunc`←0, `key_len`←0; go to FILL.
- **`key_len`** equals `cnt` and saturates at `KEY_BYTES`.
- **Empty messages do not exist.** Every transfer carries a data byte, so `key_len` ≥ 1 whenever `key_valid`=1.
- **Inputs ignored when no transfer occurs.** `in_byte` and `in_last` have no effect unless a transfer occurs. `in_valid` may drop between bytes with no effect.
- **Reset**, asynchronous, at any time including mid-message or in HOLD:
  - state=FILL, `cnt`=0, `key`=0, `key_len`=0, `key_trunc`=0;
  - hence `key_valid`=0 and `in_ready`=1;
  - partial messages are lost.
- **Consumer.** The hash consumer is combinational, so `pearson.hash` is valid whenever `key_valid`=1.

## Timing
- **Key-output latency.** `key_valid` rises one cycle after the edge that accepts the terminating byte:
  - in FILL, the byte with `in_last`=1;
  - in DROP, the byte with `in_last`=1.
- **No bypass.** In HOLD, `in_ready`=0, and it returns to 1 in the cycle after the output transfer. The minimum period is n+1 cycles per n-byte message (n ≤ `KEY_BYTES`), i.e. 6 cycles for a full 5-byte key.
- **`key_ready` in FILL/DROP.** `key_ready` asserted while `key_valid`=0 is ignored.
- **Lane writes.** Each lane write is visible on `key` in the cycle after its transfer. Partial keys are visible but not valid.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-cycle → `key`=0, `key_len`=0, `key_trunc`=0, `key_valid`=0, `in_ready`=1 immediately (asynchronous), with no clock edge needed.
- **Single byte.** Send `'h'` (8'd104) with `in_last`=1, `key_ready`=1 → `key`=40'h68_00_00_00_00, `key_len`=1, `key_trunc`=0, `key_valid` high for exactly 1 cycle, starting 1 cycle after the transfer.
- **Full key.** Send `"hello"` back-to-back, last on `'o'` → `key`=40'h68_65_6C_6C_6F ([39:32]=104, [7:0]=111), `key_len`=5, `key_trunc`=0, no DROP state. The next message is accepted on the cycle after the output transfer.
- **Truncation.** Send `"helloworld"`, last on `'d'` → `in_ready`=1 for all 10 bytes, `key`=40'h68656C6C6F, `key_len`=5, `key_trunc`=1. `key_valid` rises the cycle after `'d'`.
- **Backpressure and gaps.** Send `"abc"` with `in_valid` gaps of 2 cycles, and hold `key_ready`=0 for 10 cycles → `key`=40'h61_62_63_00_00 and `key_len`=3 stay stable, `in_ready`=0 throughout HOLD. On `key_ready`=1, the key is cleared and `in_ready`=1 next cycle.
- **Reset mid-message.** Send 3 bytes of `"hello"`, then pulse `rst_n` low, then send `"a"` with last → `key`=40'h61_00_00_00_00, `key_len`=1, with no residue of `'h','e','l'`.

Source files
------------

// File: rtl/pearson_key_packer.sv
// pearson_key_packer
//   Packs a valid/ready byte stream into a zero-padded key for the
//   combinational pearson hash stage. The first byte of a message lands in
//   the most-significant lane. Messages longer than KEY_BYTES are truncated
//   and flagged. The key is held on the output handshake until it is taken.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_byte    : message byte
//   in_valid   : in_byte / in_last valid
//   in_last    : this byte ends the message
//   in_ready   : packer accepts a byte this cycle
//   key        : packed key, byte i at [8*(KEY_BYTES-i)-1 -: 8]
//   key_len    : bytes stored (1..KEY_BYTES while key_valid)
//   key_trunc  : message was longer than KEY_BYTES
//   key_valid  : key / key_len / key_trunc valid
//   key_ready  : consumer takes the key this cycle
module pearson_key_packer #(
  parameter int unsigned KEY_BYTES = 5,
  localparam int unsigned LEN_W    = $clog2(KEY_BYTES + 1),
  localparam int unsigned KEY_W    = 8 * KEY_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [KEY_W-1:0] key,
  output logic [LEN_W-1:0] key_len,
  output logic             key_trunc,
  output logic             key_valid,
  input  logic             key_ready
);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_DROP,
    ST_HOLD
  } state_e;

  localparam logic [LEN_W-1:0] LAST_LANE = LEN_W'(KEY_BYTES - 1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q,   cnt_d;
  logic [KEY_W-1:0]   key_q,   key_d;
  logic               trunc_q, trunc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    trunc_d = trunc_q;

    unique case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < KEY_BYTES; i++) begin
            if (cnt_q == LEN_W'(i)) begin
              key_d[8*(KEY_BYTES-i)-1 -: 8] = in_byte;
            end
          end
          cnt_d = cnt_q + LEN_W'(1);
          // in_last wins over a full key: an exact-length message is not truncated
          if (in_last) begin
            state_d = ST_HOLD;
          end else if (cnt_q == LAST_LANE) begin
            state_d = ST_DROP;
          end
        end
      end

      ST_DROP: begin
        if (in_valid) begin
          trunc_d = 1'b1;
          if (in_last) begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (key_ready) begin
          key_d   = '0;
          cnt_d   = '0;
          trunc_d = 1'b0;
          state_d = ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      key_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      trunc_q <= trunc_d;
    end
  end

  assign in_ready  = (state_q != ST_HOLD);
  assign key_valid = (state_q == ST_HOLD);
  assign key       = key_q;
  assign key_len   = cnt_q;
  assign key_trunc = trunc_q;

endmodule

// File: tb/tb_pearson_key_packer.sv
// tb_pearson_key_packer
//   Self-checking bench for pearson_key_packer (KEY_BYTES = 5).
//   Expected keys are pushed to a scoreboard queue when a message is sent and
//   compared when the output handshake completes.
module tb_pearson_key_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [39:0] key;
  logic [2:0]  key_len;
  logic        key_trunc;
  logic        key_valid;
  logic        key_ready;

  pearson_key_packer #(.KEY_BYTES(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .key       (key),
    .key_len   (key_len),
    .key_trunc (key_trunc),
    .key_valid (key_valid),
    .key_ready (key_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] key;
    logic [2:0]  len;
    logic        trunc;
  } exp_t;

  typedef struct {
    string       msg;
    logic [39:0] key;
    logic [2:0]  len;
    logic        trunc;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int idx, input string m, input logic [39:0] k,
                         input logic [2:0] l, input logic t);
    vecs[idx].msg   = m;
    vecs[idx].key   = k;
    vecs[idx].len   = l;
    vecs[idx].trunc = t;
  endtask

  task automatic push_exp(input logic [39:0] k, input logic [2:0] l, input logic t);
    exp_t e;
    e.key   = k;
    e.len   = l;
    e.trunc = t;
    sb.push_back(e);
  endtask

  // Drive one byte from edge+1 until it is accepted; returns at edge+1 after
  // the accepting edge with in_valid dropped and garbage on in_byte/in_last.
  task automatic send_byte(input logic [7:0] b, input logic last, output int stalls);
    in_byte  = b;
    in_last  = last;
    in_valid = 1'b1;
    stalls   = 0;
    while (!in_ready && stalls < 50) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stuck at 0 expected 1 within 50 cycles");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic send_msg(input string s, input logic last_on_end, output int stalls_total);
    int st;
    stalls_total = 0;
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], last_on_end && (i == s.len() - 1), st);
      stalls_total += st;
    end
  endtask

  // Wait until every pushed key has been consumed, then confirm the clear.
  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_drained"}, 64'(sb.size()), 64'd0);
    chk({name, "_clr_valid"}, 64'(key_valid), 64'd0);
    chk({name, "_clr_ready"}, 64'(in_ready), 64'd1);
    chk({name, "_clr_key"}, 64'(key), 64'd0);
    chk({name, "_clr_len"}, 64'(key_len), 64'd0);
    chk({name, "_clr_trunc"}, 64'(key_trunc), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    exp_t e;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    in_byte   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    key_ready = 1'b1;

    set_vec(0, "h",          40'h68_00_00_00_00, 3'd1, 1'b0);
    set_vec(1, "hello",      40'h68_65_6C_6C_6F, 3'd5, 1'b0);
    set_vec(2, "helloworld", 40'h68_65_6C_6C_6F, 3'd5, 1'b1);
    set_vec(3, "abcdef",     40'h61_62_63_64_65, 3'd5, 1'b1);
    set_vec(4, "abcd",       40'h61_62_63_64_00, 3'd4, 1'b0);
    set_vec(5, "xyz",        40'h78_79_7A_00_00, 3'd3, 1'b0);
    set_vec(6, "Q",          40'h51_00_00_00_00, 3'd1, 1'b0);

    // Scoreboard monitor: a transfer happens at the next rising edge when
    // key_valid & key_ready are seen on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && key_valid) begin
          chk("hold_in_ready", 64'(in_ready), 64'd0);
          if (key_ready) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_key: got key 0x%0h expected none", key);
            end else begin
              e = sb.pop_front();
              chk("sb_key", 64'(key), 64'(e.key));
              chk("sb_len", 64'(key_len), 64'(e.len));
              chk("sb_trunc", 64'(key_trunc), 64'(e.trunc));
            end
          end
        end
      end
    join_none

    // Asynchronous reset: outputs settle with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_key", 64'(key), 64'd0);
    chk("rst_len", 64'(key_len), 64'd0);
    chk("rst_trunc", 64'(key_trunc), 64'd0);
    chk("rst_valid", 64'(key_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table: back-to-back bytes with key_ready held high throughout.
    for (int v = 0; v < 7; v++) begin
      push_exp(vecs[v].key, vecs[v].len, vecs[v].trunc);
      send_msg(vecs[v].msg, 1'b1, st);
      chk({"tbl_stalls_", vecs[v].msg}, 64'(st), 64'd0);
      chk({"tbl_latency_", vecs[v].msg}, 64'(key_valid), 64'd1);
      drain({"tbl_", vecs[v].msg});
    end

    // Full key immediately followed by another message: the next byte waits
    // exactly one cycle (the HOLD cycle).
    push_exp(40'h68_65_6C_6C_6F, 3'd5, 1'b0);
    push_exp(40'h61_00_00_00_00, 3'd1, 1'b0);
    send_msg("hello", 1'b1, st);
    chk("full_stalls", 64'(st), 64'd0);
    send_byte(8'h61, 1'b1, st);
    chk("full_next_stall", 64'(st), 64'd1);
    drain("full_next");

    // Gaps on in_valid and a 10-cycle backpressure hold.
    key_ready = 1'b0;
    push_exp(40'h61_62_63_00_00, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h61 + 8'(i), i == 2, st);
      if (i < 2) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    chk("gap_partial_len", 64'(key_len), 64'd3);
    in_valid = 1'b1;
    in_byte  = 8'hEE;
    in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 64'(key_valid), 64'd1);
      chk("bp_key", 64'(key), 64'h61_62_63_00_00);
      chk("bp_len", 64'(key_len), 64'd3);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    key_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_release_key", 64'(key), 64'd0);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-message: no residue of the partial bytes.
    send_msg("hel", 1'b0, st);
    chk("mid_partial_key", 64'(key), 64'h68_65_6C_00_00);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_key", 64'(key), 64'd0);
    chk("mid_rst_len", 64'(key_len), 64'd0);
    rst_n = 1'b1;
    push_exp(40'h61_00_00_00_00, 3'd1, 1'b0);
    send_msg("a", 1'b1, st);
    drain("mid_rst");

    // Reset while holding a key.
    key_ready = 1'b0;
    send_msg("ab", 1'b1, st);
    chk("hold_pre_rst_valid", 64'(key_valid), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("hold_rst_valid", 64'(key_valid), 64'd0);
    chk("hold_rst_ready", 64'(in_ready), 64'd1);
    chk("hold_rst_key", 64'(key), 64'd0);
    rst_n     = 1'b1;
    key_ready = 1'b1;
    push_exp(40'h7A_00_00_00_00, 3'd1, 1'b0);
    send_msg("z", 1'b1, st);
    drain("hold_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
